fib_seq_gen: RTL

Parametrised Fibonacci sequence generator. Each run is started by a command that loads two programmable seeds and a term count. It emits exactly that many terms on a valid/ready output stream, marks the final term, and pulses `done` when the run ends. Arithmetic wraps or saturates per instance, and overflow is detected and flagged. It replaces the fixed 32-bit free-running Fibonacci counter as the sequence source for downstream test-pattern and checker logic.

---
 rtl/fib_pkg.sv | 38 +++
 rtl/fib_adder.sv | 27 ++
 rtl/fib_seq_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci sequence generator: FSM state encoding,
// the packed run-state record and its reset value.
package fib_pkg;

  // Run phases: waiting for a command, streaming terms, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  // Control state of one run, kept together so a checker can bind to a
  // single signal and see the phase plus every overflow flag at once.
  //   prev_ovf : the term currently presented descends from a carrying add
  //   curr_ovf : the term queued behind it descends from a carrying add
  //   overflow : an overflowed term has been handed to the consumer this run
  typedef struct packed {
    fib_state_e state;
    logic       prev_ovf;
    logic       curr_ovf;
    logic       overflow;
  } fib_run_t;

  localparam fib_run_t RUN_RESET = '{
    state:    IDLE,
    prev_ovf: 1'b0,
    curr_ovf: 1'b0,
    overflow: 1'b0
  };

  // A new term is tainted if its own add carried or either parent was tainted.
  function automatic logic ovf_inherit(input logic carry,
                                       input logic prev_ovf,
                                       input logic curr_ovf);
    return carry | prev_ovf | curr_ovf;
  endfunction

endpackage

// File: rtl/fib_adder.sv
// Full-width adder used to form the next Fibonacci term. The carry out is
// always reported; the sum either wraps modulo 2^WIDTH or clamps to
// all-ones when the add carries, chosen per instance.
module fib_adder #(
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full;

  // Widen by one bit so the carry is captured, then wrap or clamp.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    carry = full[WIDTH];
    if ((SATURATE != 0) && full[WIDTH]) begin
      sum = '1;
    end else begin
      sum = full[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Programmable Fibonacci sequence generator. A start command captures two
// seeds and a term count; the block then streams exactly that many terms,
// flags the final one, tracks overflow per term and per run, and pulses
// done once the run has ended.
//
// Output handshake: a term is transferred on a rising clk edge where
// out_valid and out_ready are both high. While out_valid is high and
// out_ready is low, out_data, out_last and out_ovf hold their values.
// out_valid never depends on out_ready, and once raised it stays high
// until the term is taken. Every output is decoded from registered state
// only, so out_ready has no combinational path to any output.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] num_terms,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_ovf,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Control state (phase and overflow flags) as one bindable record.
  fib_run_t run_q;
  fib_run_t run_d;

  // Datapath: the term on the output, the term behind it, terms left.
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;
  logic [WIDTH-1:0] curr_q;
  logic [WIDTH-1:0] curr_d;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;

  // Next-term adder outputs.
  logic [WIDTH-1:0] next_term;
  logic             next_carry;

  // Decoded helpers.
  logic in_run;
  logic xfer;
  logic on_last;

  fib_adder #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_adder (
    .a     (prev_q),
    .b     (curr_q),
    .sum   (next_term),
    .carry (next_carry)
  );

  assign in_run  = (run_q.state == RUN);
  assign on_last = (rem_q == CNT_ONE);
  assign xfer    = in_run & out_ready;

  // Outputs are pure decodes of the registered state; outside RUN the
  // term outputs read as zero so idle and reset look identical.
  assign out_valid = in_run;
  assign out_data  = in_run ? prev_q : '0;
  assign out_ovf   = in_run & run_q.prev_ovf;
  assign out_last  = in_run & on_last;
  assign busy      = in_run;
  assign done      = (run_q.state == DONE);
  assign overflow  = run_q.overflow;

  // Control state register; reset aborts any run with no completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= RUN_RESET;
    end else begin
      run_q <= run_d;
    end
  end

  // Datapath registers for the two live terms and the remaining count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      curr_q <= '0;
      rem_q  <= '0;
    end else begin
      prev_q <= prev_d;
      curr_q <= curr_d;
      rem_q  <= rem_d;
    end
  end

  // Next-state and datapath update: capture on start in IDLE, shift the
  // term pair on each transfer in RUN, single-cycle DONE back to IDLE.
  always_comb begin
    run_d  = run_q;
    prev_d = prev_q;
    curr_d = curr_q;
    rem_d  = rem_q;

    case (run_q.state)
      IDLE: begin
        if (start) begin
          prev_d         = seed0;
          curr_d         = seed1;
          rem_d          = num_terms;
          run_d.prev_ovf = 1'b0;
          run_d.curr_ovf = 1'b0;
          run_d.overflow = 1'b0;
          // A zero-length run skips straight to the completion pulse.
          run_d.state    = (num_terms != CNT_ZERO) ? RUN : DONE;
        end
      end

      RUN: begin
        if (xfer) begin
          prev_d         = curr_q;
          curr_d         = next_term;
          run_d.prev_ovf = run_q.curr_ovf;
          run_d.curr_ovf = ovf_inherit(next_carry, run_q.prev_ovf,
                                       run_q.curr_ovf);
          rem_d          = rem_q - CNT_ONE;
          // The sticky flag records tainted terms the consumer accepted.
          if (run_q.prev_ovf) begin
            run_d.overflow = 1'b1;
          end
          if (on_last) begin
            run_d.state = DONE;
          end
        end
      end

      DONE: begin
        // Any start seen here is dropped; the next one is taken in IDLE.
        run_d.state = IDLE;
      end

      default: begin
        run_d.state = IDLE;
      end
    endcase
  end

endmodule
